// File: rtl/instr_encoder_loader_pkg.sv
// Shared instruction-format definitions: class codes, opcodes and field positions.
// The control decoder imports this package too, so encoder and decoder cannot drift apart.
package instr_encoder_loader_pkg;

  typedef enum logic [2:0] {
    CLS_RTYPE   = 3'd0,
    CLS_JUMP    = 3'd1,
    CLS_BRANCH  = 3'd2,
    CLS_ADDI    = 3'd3,
    CLS_ALUI0   = 3'd4,
    CLS_LOAD    = 3'd5,
    CLS_STORE   = 3'd6,
    CLS_ILLEGAL = 3'd7
  } instr_class_e;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_JUMP   = 6'b000100;
  localparam logic [5:0] OP_BRANCH = 6'b001100;
  localparam logic [5:0] OP_ADDI   = 6'b001110;
  localparam logic [5:0] OP_ALUI0  = 6'b001111;
  localparam logic [5:0] OP_LOAD   = 6'b100100;
  localparam logic [5:0] OP_STORE  = 6'b100110;

  localparam int OP_LSB    = 26;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_LSB   = 0;
  localparam int TGT_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } load_state_e;

  function automatic logic [5:0] class_opcode(input instr_class_e c);
    case (c)
      CLS_RTYPE:  return OP_RTYPE;
      CLS_JUMP:   return OP_JUMP;
      CLS_BRANCH: return OP_BRANCH;
      CLS_ADDI:   return OP_ADDI;
      CLS_ALUI0:  return OP_ALUI0;
      CLS_LOAD:   return OP_LOAD;
      CLS_STORE:  return OP_STORE;
      default:    return OP_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Symbolic-instruction stream from the boot/test host into the encoder.
interface instr_encoder_loader_if;
  import instr_encoder_loader_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic         in_last;
  instr_class_e in_class;
  logic [4:0]   in_rs;
  logic [4:0]   in_rt;
  logic [4:0]   in_rd;
  logic [3:0]   in_funct;
  logic [15:0]  in_imm;
  logic [25:0]  in_target;

  modport master (
    output in_valid, in_last, in_class, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, in_class, in_rs, in_rt, in_rd, in_funct, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_loader_word_enc.sv
// Combinational fields-to-word encoder; legal=0 flags the reserved class.
module instr_word_enc
  import instr_encoder_loader_pkg::*;
(
  input  instr_class_e cls,
  input  logic [4:0]   rs,
  input  logic [4:0]   rt,
  input  logic [4:0]   rd,
  input  logic [3:0]   funct,
  input  logic [15:0]  imm,
  input  logic [25:0]  target,
  output logic [31:0]  word,
  output logic         legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    word[OP_LSB +: 6] = class_opcode(cls);
    case (cls)
      CLS_RTYPE: begin
        // shamt and the two bits above funct stay zero
        word[RS_LSB +: 5]    = rs;
        word[RT_LSB +: 5]    = rt;
        word[RD_LSB +: 5]    = rd;
        word[FUNCT_LSB +: 4] = funct;
      end
      CLS_JUMP: word[TGT_LSB +: 26] = target;
      CLS_ILLEGAL: begin
        word  = '0;
        legal = 1'b0;
      end
      default: begin
        word[RS_LSB +: 5]   = rs;
        word[RT_LSB +: 5]   = rt;
        word[IMM_LSB +: 16] = imm;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Session loader: accepts instruction fields, encodes them and writes imem at consecutive
// addresses from BASE_ADDR, with one cycle of latency and sticky error reporting.
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  instr_encoder_loader_if.slave in_if,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W:0]       word_count,
  output logic                  err_illegal,
  output logic                  err_overflow
);

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ill_q, ill_d;
  logic              ovf_q, ovf_d;
  logic              ready;
  logic              accept;
  logic [31:0]       enc_word;
  logic              enc_legal;

  instr_word_enc u_enc (
    .cls    (in_if.in_class),
    .rs     (in_if.in_rs),
    .rt     (in_if.in_rt),
    .rd     (in_if.in_rd),
    .funct  (in_if.in_funct),
    .imm    (in_if.in_imm),
    .target (in_if.in_target),
    .word   (enc_word),
    .legal  (enc_legal)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ill_d   = ill_q;
    ovf_d   = ovf_q;
    ready   = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    accept  = in_if.in_valid && ready;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = BASE_C;
          count_d = '0;
          ill_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (enc_legal) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = enc_word;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
          end else begin
            ill_d = 1'b1;
          end
          // A legal word filling the last slot without in_last ends the session early
          if (in_if.in_last) begin
            state_d = ST_FLUSH;
          end else if (enc_legal && (count_q + 1'b1 == DEPTH_C)) begin
            ovf_d   = 1'b1;
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= BASE_C;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_C;
      wdata_q <= '0;
      ill_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ill_q   <= ill_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_if.in_ready = ready;
  assign imem_we        = we_q;
  assign imem_addr      = addr_q;
  assign imem_wdata     = wdata_q;
  assign word_count     = count_q;
  assign err_illegal    = ill_q;
  assign err_overflow   = ovf_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: directed sessions plus randomized sessions checked
// against a session-level model built from the instruction-format rules.
module tb_instr_encoder_loader;
  import instr_encoder_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int BASE   = 16;
  localparam int DEPTH  = 4;

  typedef struct {
    int cls; int rs; int rt; int rd; int funct; int imm; int tgt; bit last;
  } instr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   word_count;
  logic              err_illegal;
  logic              err_overflow;

  int vectors = 0;
  int miscompares = 0;

  logic [39:0] wr_total[$];
  int          done_total = 0;

  always #5 clk = ~clk;

  instr_encoder_loader_if ifc ();

  instr_encoder_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start   (load_start),
    .in_if        (ifc),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .busy         (busy),
    .done         (done),
    .word_count   (word_count),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow)
  );

  always @(negedge clk) begin
    if (imem_we) wr_total.push_back({imem_addr, imem_wdata});
    if (done) done_total++;
  end

  function automatic logic [31:0] ref_enc(input instr_t t);
    longint op;
    longint w;
    case (t.cls)
      0: op = 0;  1: op = 4;  2: op = 12; 3: op = 14;
      4: op = 15; 5: op = 36; default: op = 38;
    endcase
    if (t.cls == 0)      w = op * 67108864 + t.rs * 2097152 + t.rt * 65536 + t.rd * 2048 + t.funct;
    else if (t.cls == 1) w = op * 67108864 + t.tgt;
    else                 w = op * 67108864 + t.rs * 2097152 + t.rt * 65536 + t.imm;
    return 32'(w);
  endfunction

  function automatic instr_t mk(input int cls, rs, rt, rd, funct, imm, tgt, input bit last);
    instr_t t;
    t.cls = cls; t.rs = rs; t.rt = rt; t.rd = rd; t.funct = funct;
    t.imm = imm; t.tgt = tgt; t.last = last;
    return t;
  endfunction

  function automatic instr_t rnd(input bit last, input bit allow_ill);
    int c;
    c = (allow_ill && ($urandom_range(0, 5) == 0)) ? 7 : int'($urandom_range(0, 6));
    return mk(c, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 15), $urandom_range(0, 65535), $urandom_range(0, 67108863), last);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic push(input instr_t t, output bit ok);
    ifc.in_valid  = 1'b1;
    ifc.in_last   = t.last;
    ifc.in_class  = instr_class_e'(3'(t.cls));
    ifc.in_rs     = 5'(t.rs);
    ifc.in_rt     = 5'(t.rt);
    ifc.in_rd     = 5'(t.rd);
    ifc.in_funct  = 4'(t.funct);
    ifc.in_imm    = 16'(t.imm);
    ifc.in_target = 26'(t.tgt);
    ok = 1'b0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(negedge clk);
      if (ifc.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic run_session(input instr_t list[$], input int gap_max, input bit poke);
    logic [39:0] exp_q[$];
    logic [39:0] e;
    int  wr0, d0, cnt, g;
    bit  ill, ovf, ended, ok;
    wr0 = wr_total.size(); d0 = done_total; cnt = 0;
    ill = 0; ovf = 0; ended = 0;
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_count", word_count, 0);
    chk("start_err_illegal", err_illegal, 0);
    chk("start_err_overflow", err_overflow, 0);
    foreach (list[i]) begin
      g = $urandom_range(0, gap_max);
      repeat (g) begin @(posedge clk); #1; end
      if (poke && i == 1) pulse_start();
      push(list[i], ok);
      chk("accept", ok, !ended);
      if (!ok || ended) break;
      if (list[i].cls == 7) begin
        ill = 1;
        chk("illegal_no_write", imem_we, 0);
      end else begin
        e = {8'(BASE + cnt), ref_enc(list[i])};
        exp_q.push_back(e);
        cnt++;
        chk("write_we", imem_we, 1);
        chk("write_addr", imem_addr, e[39:32]);
        chk("write_data", imem_wdata, e[31:0]);
      end
      chk("count_step", word_count, cnt);
      if (list[i].last) ended = 1;
      else if (list[i].cls != 7 && cnt == DEPTH) begin ovf = 1; ended = 1; end
      if (ended) chk("ready_drop", ifc.in_ready, 0);
    end
    for (int c = 0; c < 10 && busy; c++) begin @(posedge clk); #1; end
    chk("busy_end", busy, 0);
    chk("done_pulses", done_total - d0, 1);
    chk("write_total", wr_total.size() - wr0, exp_q.size());
    foreach (exp_q[k]) if (wr0 + k < wr_total.size()) chk("write_log", wr_total[wr0 + k], exp_q[k]);
    chk("final_count", word_count, cnt);
    chk("final_err_illegal", err_illegal, ill);
    chk("final_err_overflow", err_overflow, ovf);
  endtask

  initial begin
    instr_t lst[$];
    instr_t t;
    bit     ok;
    int     legal;
    bit     nolast;
    int     n;

    rst = 1'b1; load_start = 1'b0;
    ifc.in_valid = 1'b0; ifc.in_last = 1'b0; ifc.in_class = CLS_RTYPE;
    ifc.in_rs = '0; ifc.in_rt = '0; ifc.in_rd = '0; ifc.in_funct = '0;
    ifc.in_imm = '0; ifc.in_target = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, BASE);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", word_count, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_overflow", err_overflow, 0);
    chk("rst_ready", ifc.in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single R-type word
    lst.delete();
    lst.push_back(mk(0, 1, 2, 3, 2, 0, 0, 1));
    run_session(lst, 0, 0);
    chk("rtype_word", wr_total[wr_total.size() - 1], {8'(BASE), 32'h00221802});

    // LOAD then JUMP at consecutive addresses
    lst.delete();
    lst.push_back(mk(5, 4, 5, 0, 0, 16'h0010, 0, 0));
    lst.push_back(mk(1, 0, 0, 0, 0, 0, 26'h40, 1));
    run_session(lst, 0, 0);
    chk("load_word", wr_total[wr_total.size() - 2], {8'(BASE), 32'h90850010});
    chk("jump_word", wr_total[wr_total.size() - 1], {8'(BASE + 1), 32'h10000040});

    // three words with gaps and a load_start while busy
    lst.delete();
    lst.push_back(rnd(0, 0)); lst.push_back(rnd(0, 0)); lst.push_back(rnd(1, 0));
    run_session(lst, 3, 1);

    // illegal class in mid-stream
    lst.delete();
    lst.push_back(mk(3, 7, 8, 9, 1, 16'h1234, 0, 0));
    lst.push_back(mk(7, 1, 1, 1, 1, 1, 1, 0));
    lst.push_back(mk(6, 2, 3, 4, 5, 16'hbeef, 0, 1));
    run_session(lst, 1, 0);

    // six words with no in_last against DEPTH=4
    lst.delete();
    for (int i = 0; i < 6; i++) lst.push_back(rnd(0, 0));
    run_session(lst, 1, 0);

    // reset in the middle of a session
    pulse_start();
    push(rnd(0, 0), ok);
    push(rnd(0, 0), ok);
    chk("pre_rst_count", word_count, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_we", imem_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", word_count, 0);
    chk("midrst_addr", imem_addr, BASE);
    chk("midrst_wdata", imem_wdata, 0);
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("postrst_we", imem_we, 0);
    lst.delete();
    lst.push_back(rnd(0, 0)); lst.push_back(rnd(1, 0));
    run_session(lst, 0, 0);

    // randomized sessions
    for (int s = 0; s < 12; s++) begin
      lst.delete();
      nolast = ($urandom_range(0, 3) == 0);
      if (nolast) begin
        legal = 0;
        while (legal < DEPTH) begin
          t = rnd(0, 1);
          if (t.cls != 7) legal++;
          lst.push_back(t);
        end
        lst.push_back(rnd(0, 1));
        lst.push_back(rnd(1, 1));
      end else begin
        n = $urandom_range(1, 6);
        for (int i = 0; i < n; i++) lst.push_back(rnd(i == n - 1, 1));
      end
      run_session(lst, 2, (s % 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
